hilo_muldiv: RTL
================

Name: hilo_muldiv

Overview:
- Multiply/divide unit with the HI/LO architectural registers; sits beside the EX-stage combinational ALU and consumes the same X/Y operands.
- Replaces the single-cycle divide path with a 32-iteration restoring divider, so EX timing is not set by a combinational 32-bit divide.
- Multiply stays single-cycle.
- The pipeline stalls on busy; MFHI/MFLO read hi/lo directly.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits; divider iterations = WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  issue op this cycle (qualified by op).
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- X  input  WIDTH  operand 1 (dividend / multiplicand / MTHI-MTLO source).
- Y  input  WIDTH  operand 2 (divisor / multiplier).
- busy  output  1  divide in progress; pipeline must hold MFHI/MFLO/MT*/new muldiv ops.
- done  output  1  one-cycle pulse in the cycle after hi/lo take a MULT/DIV result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any time including mid-divide):
  - hi=0, lo=0, busy=0, done=0, state=IDLE.
  - Divider datapath cleared; an in-flight divide is aborted and no result is written.
- States: IDLE, DIV, FIX. busy = (state != IDLE), registered.
- Notation: E0 is the edge that samples start.
- IDLE, start with op MULT/MULTU at E0:
  - {hi,lo} <= full 2*WIDTH product, signed for MULT, unsigned for MULTU.
  - done=1 for the following cycle only; busy stays 0.
- IDLE, start with op MTHI/MTLO at E0: hi<=X (resp. lo<=X); done stays 0.
- IDLE, start with op DIV/DIVU at E0:
  - Latch the dividend and divisor magnitudes (absolute values for DIV, raw for DIVU).
  - Latch the quotient sign (X[31]^Y[31]) and remainder sign (X[31]), DIV only.
  - Latch a divide-by-zero flag (Y==0).
  - Clear partial remainder and iteration counter; go to DIV.
- DIV: one restoring step per cycle.
  - Shift {rem,quo} left 1, trial subtract divisor, set quotient bit if non-negative.
  - Counter 0..WIDTH-1; after step WIDTH-1 (edge E32) go to FIX.
- FIX, edge E33:
  - Write lo=quotient and hi=remainder, each negated if its latched sign is set (DIV only).
  - Go to IDLE; done=1 for one cycle.
- Divide timing: busy is high for exactly WIDTH+1 = 33 cycles (after E0 through after E32). The result is visible on hi/lo the cycle after E33.
- Divide by zero (DIV and DIVU): lo=all ones, hi=X (original dividend, unnegated). Same 33-cycle latency.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out naturally from the magnitude algorithm with WIDTH-bit wraparound and must not be special-cased wrongly.
- Signed rounding: quotient truncates toward zero; remainder takes the dividend's sign.
- start while busy (any op): ignored; no state or register change. The pipeline must not issue, but the unit is robust to it.
- op 6/7 with start: no effect.
- hi/lo are stable and readable whenever busy=0. During busy, hi/lo hold their pre-divide values until the FIX edge.
- done is never asserted by MTHI/MTLO or ignored starts.
- The multiplier is a single combinational 64-bit product registered into hi/lo; no pipelining.

Test Plan:
- MULTU X=0xFFFFFFFF, Y=2 -> after 1 edge: hi=0x00000001, lo=0xFFFFFFFE, done pulse 1 cycle, busy never high.
- MULT X=0xFFFFFFFD (-3), Y=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then MTHI X=0x12345678 -> hi=0x12345678, lo unchanged, no done.
- DIVU X=100, Y=7 -> busy high exactly 33 cycles, hi/lo unchanged meanwhile, then lo=14, hi=2, done 1 cycle.
- DIV X=0xFFFFFFF9 (-7), Y=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU X=5, Y=0 -> lo=0xFFFFFFFF, hi=5.
- DIVU 100/7 with MULTU start asserted at busy cycle 10 -> MULTU ignored, final lo=14, hi=2.
- Separate run: rst pulsed at busy cycle 15 -> hi=lo=0, busy=0 immediately, no done afterwards.

Source files
------------

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: single-cycle MULT/MULTU, 32-step restoring DIV/DIVU,
// MTHI/MTLO writes. busy covers the whole divide; done pulses after a result lands.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d, busy_q, busy_d;
  logic [WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, xraw_q, xraw_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic [2*WIDTH-1:0]   prod_s_s, prod_u_s;
  logic [WIDTH:0]       rem_sh_s;
  logic                 take_s;
  logic                 is_div_s;

  // Next-state, divider step and HI/LO update
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    xraw_d   = xraw_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    prod_s_s = {{WIDTH{X[WIDTH-1]}}, X} * {{WIDTH{Y[WIDTH-1]}}, Y};
    prod_u_s = {{WIDTH{1'b0}}, X} * {{WIDTH{1'b0}}, Y};
    is_div_s = (op == OP_DIV);
    // Divisor is at most 2^WIDTH-1, so remainder-after-subtract always fits in WIDTH bits.
    rem_sh_s = {rem_q, quo_q[WIDTH-1]};
    take_s   = (rem_sh_s >= {1'b0, dvs_q});

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              {hi_d, lo_d} = prod_s_s;
              done_d       = 1'b1;
            end
            OP_MULTU: begin
              {hi_d, lo_d} = prod_u_s;
              done_d       = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              quo_d   = neg_if(X, is_div_s & X[WIDTH-1]);
              dvs_d   = neg_if(Y, is_div_s & Y[WIDTH-1]);
              qneg_d  = is_div_s & (X[WIDTH-1] ^ Y[WIDTH-1]);
              rneg_d  = is_div_s & X[WIDTH-1];
              dz_d    = (Y == {WIDTH{1'b0}});
              xraw_d  = X;
              rem_d   = {WIDTH{1'b0}};
              cnt_d   = {CW{1'b0}};
              state_d = S_DIV;
            end
            OP_MTHI: hi_d = X;
            OP_MTLO: lo_d = X;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        if (take_s) begin
          rem_d = rem_sh_s[WIDTH-1:0] - dvs_q;
        end else begin
          rem_d = rem_sh_s[WIDTH-1:0];
        end
        quo_d = {quo_q[WIDTH-2:0], take_s};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          state_d = S_DIV;
        end
      end
      S_FIX: begin
        if (dz_q) begin
          lo_d = {WIDTH{1'b1}};
          hi_d = xraw_q;
        end else begin
          lo_d = neg_if(quo_q, qneg_q);
          hi_d = neg_if(rem_q, rneg_q);
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset aborts any divide in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rem_q   <= {WIDTH{1'b0}};
      quo_q   <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      xraw_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      xraw_q  <= xraw_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
